uart_rx_to_reg: RTL

Serial receive stage that consumes the `txd_pin` stream produced by the message transmitter on the other side of the link. It deserialises 8N1 UART frames, assembles `M/N` consecutive bytes into one `M`-bit register and presents the message with a one-cycle valid strobe. It is the far-end counterpart of the transmitter: the first byte received lands in the most significant byte of `data`, matching how the transmitter slices its message.

---
 rtl/uart_rx_to_reg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_to_reg.sv
// 8N1 UART receiver that packs M/N consecutive bytes into one M-bit message register.
// The first byte received lands in the most significant byte of data.
module uart_rx_to_reg #(
    parameter int N                 = 8,
    parameter int M                 = 128,
    parameter int CLKS_PER_BIT      = 10417,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rxd_pin,
    output logic [M-1:0] data,
    output logic         data_valid,
    output logic [3:0]   led
);

    localparam int BYTES      = M / N;
    localparam int IDLE_LIMIT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W      = $clog2(N + 1);
    localparam int BCNT_W     = $clog2(BYTES + 1);
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(IDLE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_d;

    logic              rx_meta, rx_s, rx_prev;
    logic              fall;
    logic [CNT_W-1:0]  clk_cnt, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [N-1:0]      shreg, shreg_d;
    logic              accept, frame_err;
    logic [M-1:0]      asm;
    logic [BCNT_W-1:0] byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              led_msg, led_err;

    assign fall = rx_prev & ~rx_s;
    assign led  = {~rx_s, led_err, led_msg, (byte_cnt != '0)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
        end
    end

    // Bit timing is locked to the detected start edge; every sample is taken at mid-bit.
    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        accept    = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_TERM) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == FULL_TERM) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_s, shreg[N-1:1]};
                    if (bit_cnt == LAST_BIT) state_d = STOP;
                    else bit_cnt_d = bit_cnt + BIT_W'(1);
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt == FULL_TERM) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    accept    = rx_s;
                    frame_err = ~rx_s;
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            asm        <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            led_msg    <= 1'b0;
            led_err    <= 1'b0;
        end else begin
            rx_meta    <= rxd_pin;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            data_valid <= 1'b0;
            if (frame_err) led_err <= 1'b1;

            if (accept) begin
                asm      <= {asm[M-N-1:0], shreg};
                idle_cnt <= '0;
                if (byte_cnt == LAST_BYTE) begin
                    data       <= {asm[M-N-1:0], shreg};
                    data_valid <= 1'b1;
                    led_msg    <= 1'b1;
                    byte_cnt   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + BCNT_W'(1);
                end
            end else if (fall) begin
                idle_cnt <= '0;
            end else if (state == IDLE && byte_cnt != '0) begin
                // A stalled partial message is dropped so the next start begins a fresh one.
                if (idle_cnt == IDLE_TERM) begin
                    byte_cnt <= '0;
                    asm      <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule
